// File: rtl/mm_bram_tile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mm_bram_tile_ctrl
//  Purpose  : Multi-pass sequencer for the BRAM matrix-multiply datapath.
//             Each weight tile is loaded, then every activation row is swept
//             through the datapath, then the pipeline is drained. Result
//             buffer writes are delayed to match the datapath latency.
//  Revision : 1.0  initial release
// ============================================================================
module mm_bram_tile_ctrl #(
  parameter int ROW_NUM         = 32,
  parameter int K_TILES         = 4,
  parameter int PIPE_LAT        = 3,
  parameter int ROW_ADDR_WIDTH  = $clog2(ROW_NUM),
  parameter int TILE_ADDR_WIDTH = (K_TILES > 1) ? $clog2(K_TILES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       val_in,
  output logic                       rdy_in,
  output logic [ROW_ADDR_WIDTH-1:0]  rdaddr,
  output logic [TILE_ADDR_WIDTH-1:0] tile_idx,
  output logic                       wload_en,
  output logic                       dpath_sum_en,
  output logic                       dpath_result_wen,
  output logic [ROW_ADDR_WIDTH-1:0]  dpath_result_wraddr,
  output logic                       dpath_acc_clr,
  output logic                       done
);

  // Drain counter only needs to reach PIPE_LAT-1; keep at least one bit.
  localparam int DRAIN_WIDTH = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [ROW_ADDR_WIDTH-1:0]  c_ROW_LAST   = ROW_ADDR_WIDTH'(ROW_NUM - 1);
  localparam logic [TILE_ADDR_WIDTH-1:0] c_TILE_LAST  = TILE_ADDR_WIDTH'(K_TILES - 1);
  localparam logic [DRAIN_WIDTH-1:0]     c_DRAIN_LAST = DRAIN_WIDTH'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SLIDE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                     r_state;
  logic [ROW_ADDR_WIDTH-1:0]  r_row;
  logic [TILE_ADDR_WIDTH-1:0] r_tile;
  logic [DRAIN_WIDTH-1:0]     r_drain;
  logic                       r_rdy;
  logic                       r_wload;
  logic                       r_sum_en;
  logic                       r_done;

  // Write-back alignment pipeline: one stage per cycle of datapath latency.
  logic [PIPE_LAT-1:0]                     r_sr_en;
  logic [PIPE_LAT-1:0][ROW_ADDR_WIDTH-1:0] r_sr_row;
  logic [PIPE_LAT-1:0]                     r_sr_clr;

  logic w_first_tile;
  assign w_first_tile = (r_tile == '0);

  // Sequencer FSM; outputs are registered alongside the next state so each
  // flag is high exactly while the FSM sits in the corresponding state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_tile   <= '0;
      r_drain  <= '0;
      r_rdy    <= 1'b1;
      r_wload  <= 1'b0;
      r_sum_en <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_wload  <= 1'b0;
      r_sum_en <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (val_in) begin
            r_tile  <= '0;
            r_row   <= '0;
            r_rdy   <= 1'b0;
            r_wload <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_sum_en <= 1'b1;
          r_state  <= S_SLIDE;
        end
        S_SLIDE: begin
          if (r_row == c_ROW_LAST) begin
            r_row   <= '0;
            r_drain <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_row    <= r_row + ROW_ADDR_WIDTH'(1);
            r_sum_en <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_drain == c_DRAIN_LAST) begin
            if (r_tile == c_TILE_LAST) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_tile  <= r_tile + TILE_ADDR_WIDTH'(1);
              r_wload <= 1'b1;
              r_state <= S_LOAD;
            end
          end else begin
            r_drain <= r_drain + DRAIN_WIDTH'(1);
          end
        end
        S_DONE: begin
          r_rdy   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_rdy   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Delay {sum_en, row, first-tile} by PIPE_LAT cycles; reset flushes any
  // in-flight writes so nothing is written back after an abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr_en  <= '0;
      r_sr_row <= '0;
      r_sr_clr <= '0;
    end else begin
      r_sr_en[0]  <= r_sum_en;
      r_sr_row[0] <= r_row;
      r_sr_clr[0] <= r_sum_en & w_first_tile;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_sr_en[i]  <= r_sr_en[i-1];
        r_sr_row[i] <= r_sr_row[i-1];
        r_sr_clr[i] <= r_sr_clr[i-1];
      end
    end
  end

  assign rdy_in              = r_rdy;
  assign rdaddr              = r_row;
  assign tile_idx            = r_tile;
  assign wload_en            = r_wload;
  assign dpath_sum_en        = r_sum_en;
  assign done                = r_done;
  assign dpath_result_wen    = r_sr_en[PIPE_LAT-1];
  assign dpath_result_wraddr = r_sr_row[PIPE_LAT-1];
  assign dpath_acc_clr       = r_sr_clr[PIPE_LAT-1];

endmodule
`default_nettype wire
